// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//
// APB master front end that shares a single APB slave (8-bit address,
// 8-bit data) between NREQ local requesters. Requests are arbitrated
// round-robin, the IDLE -> SETUP -> ACCESS handshake is sequenced here, and
// each requester receives a one-cycle grant pulse when its request is taken
// and a one-cycle done pulse when its transfer finishes. Every output is
// registered.
//
// Configuration macro:
//   APB_ARB_BACK2BACK_EN - when defined, a completing ACCESS that sees another
//                          pending request arbitrates on the same edge and
//                          goes straight to SETUP (psel stays high).
//                          Undefined (default): always return to IDLE.
//
// Parameters:
//   NREQ    - number of requesters (2..8)
//   TIMEOUT - ACCESS cycles to wait for pready before aborting; 0 = never
//   TO_W    - timeout counter width, 2**TO_W > TIMEOUT
//
// Ports:
//   pclk, prst            clock; asynchronous active-high reset
//   req[NREQ]             per-requester request level
//   req_write[NREQ]       per-requester direction (1 = write)
//   req_addr[8*NREQ]      per-requester address, requester i at [8i+7:8i]
//   req_wdata[8*NREQ]     per-requester write data, same packing
//   gnt[NREQ]             one-hot pulse: request accepted
//   done[NREQ]            one-hot pulse: transfer finished
//   err                   pulse with done when the transfer timed out
//   rdata[8]              read data of the last successful read
//   psel, pen, pwrite     APB control
//   paddr[8], pwdata[8]   APB address / write data
//   pready, prdata[8]     APB slave response
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic                pclk,
    input  logic                prst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_write,
    input  logic [8*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic                err,
    output logic [7:0]          rdata,
    output logic                psel,
    output logic                pen,
    output logic                pwrite,
    output logic [7:0]          paddr,
    output logic [7:0]          pwdata,
    input  logic                pready,
    input  logic [7:0]          prdata
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);
    // Last ACCESS wait cycle before the abort fires.
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t              state_q, state_d;
    // last_q is both the round-robin pointer and the owner of the current
    // transfer, since the winner becomes "last" at grant time.
    logic [IDX_W-1:0]    last_q, last_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                psel_q, psel_d;
    logic                pen_q, pen_d;
    logic                pwrite_q, pwrite_d;
    logic [7:0]          paddr_q, paddr_d;
    logic [7:0]          pwdata_q, pwdata_d;
    logic [7:0]          rdata_q, rdata_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic                err_q, err_d;

    logic [NREQ-1:0]     cur_mask;
    logic [NREQ-1:0]     arb_req;
    logic                arb_found;
    logic [IDX_W-1:0]    arb_win;
    logic                complete;
    logic                start;

    assign cur_mask = NREQ'(1) << last_q;

`ifdef APB_ARB_BACK2BACK_EN
    // At ACCESS completion the finishing requester's own bit is ignored so
    // that a still-high req from it is not granted twice in a row.
    assign arb_req = (state_q == S_IDLE) ? req : (req & ~cur_mask);
`else
    assign arb_req = req;
`endif

    // Round-robin pick: first set bit scanning last+1, last+2, ... mod NREQ.
    always_comb begin
        int j;
        j         = 0;
        arb_found = 1'b0;
        arb_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(last_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!arb_found && arb_req[j]) begin
                arb_found = 1'b1;
                arb_win   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        psel_d   = psel_q;
        pen_d    = pen_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        gnt_d    = '0;
        done_d   = '0;
        err_d    = 1'b0;
        complete = 1'b0;
        start    = 1'b0;

        case (state_q)
            S_IDLE: begin
                start = arb_found;
            end
            S_SETUP: begin
                pen_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    complete = 1'b1;
                    if (!pwrite_q) begin
                        rdata_d = prdata;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    complete = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (complete) begin
                    psel_d  = 1'b0;
                    pen_d   = 1'b0;
                    done_d  = cur_mask;
                    state_d = S_IDLE;
`ifdef APB_ARB_BACK2BACK_EN
                    start   = arb_found;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Launch a new transfer; overrides the completion values above so
        // psel stays high across a back-to-back handover.
        if (start) begin
            paddr_d  = req_addr[8*arb_win +: 8];
            pwdata_d = req_wdata[8*arb_win +: 8];
            pwrite_d = req_write[arb_win];
            psel_d   = 1'b1;
            pen_d    = 1'b0;
            gnt_d    = NREQ'(1) << arb_win;
            last_d   = arb_win;
            state_d  = S_SETUP;
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q  <= S_IDLE;
            last_q   <= LAST_RST;
            cnt_q    <= '0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            psel_q   <= psel_d;
            pen_q    <= pen_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign err    = err_q;
    assign rdata  = rdata_q;
    assign psel   = psel_q;
    assign pen    = pen_q;
    assign pwrite = pwrite_q;
    assign paddr  = paddr_q;
    assign pwdata = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for apb_req_arbiter: directed scenarios plus randomized
// requesters and slave wait states, every cycle compared against a
// transaction-level reference model held in this file.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 15;

    logic                pclk = 1'b0;
    logic                prst;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     req_write;
    logic [8*NREQ-1:0]   req_addr;
    logic [8*NREQ-1:0]   req_wdata;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                err;
    logic [7:0]          rdata;
    logic                psel;
    logic                pen;
    logic                pwrite;
    logic [7:0]          paddr;
    logic [7:0]          pwdata;
    logic                pready;
    logic [7:0]          prdata;

    always #5 pclk = ~pclk;

    apb_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TO_W(4)) dut (
        .pclk(pclk), .prst(prst),
        .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .psel(psel), .pen(pen), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [7:0]      mem [256];
    bit              m_busy;
    bit              m_acc;
    int              m_cur;
    int              m_last;
    int              m_wait;
    logic [7:0]      m_addr, m_wdata;
    logic            m_write;
    logic [NREQ-1:0] e_gnt, e_done;
    logic            e_err, e_psel, e_pen;
    logic [7:0]      e_rdata;

    // Round-robin: among pending requesters, the one closest after 'last'.
    function automatic int rr_pick(input logic [NREQ-1:0] p, input int last);
        int best, bestd, d;
        best  = -1;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (p[i]) begin
                d = (i - last - 1 + NREQ) % NREQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_cur = 0; m_last = NREQ - 1; m_wait = 0;
        m_addr = 0; m_wdata = 0; m_write = 0;
        e_gnt = 0; e_done = 0; e_err = 0; e_psel = 0; e_pen = 0; e_rdata = 0;
    endtask

    task automatic model_edge();
        bit fin, may_arb;
        int w;
        logic [NREQ-1:0] pend;
        e_gnt = 0; e_done = 0; e_err = 0; fin = 0;
        may_arb = !m_busy;
        if (m_busy && m_acc) begin
            if (pready) fin = 1;
            else if (TIMEOUT != 0 && m_wait + 1 == TIMEOUT) begin fin = 1; e_err = 1; end
            else m_wait++;
        end else if (m_busy) begin
            m_acc = 1; m_wait = 0; e_pen = 1;
        end
        if (fin) begin
            e_done[m_cur] = 1'b1;
            e_psel = 0; e_pen = 0; m_busy = 0; m_acc = 0;
            if (!e_err) begin
                if (m_write) mem[m_addr] = m_wdata;
                else e_rdata = mem[m_addr];
            end
`ifdef APB_ARB_BACK2BACK_EN
            may_arb = 1;
`endif
        end
        if (may_arb) begin
            pend = req;
            if (fin) pend[m_cur] = 1'b0;
            w = rr_pick(pend, m_last);
            if (w >= 0) begin
                m_busy = 1; m_acc = 0; m_cur = w; m_last = w;
                m_addr = req_addr[8*w +: 8];
                m_wdata = req_wdata[8*w +: 8];
                m_write = req_write[w];
                e_gnt[w] = 1'b1; e_psel = 1; e_pen = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("gnt", gnt, e_gnt);
        chk("done", done, e_done);
        chk("err", err, e_err);
        chk("psel", psel, e_psel);
        chk("pen", pen, e_pen);
        chk("paddr", paddr, m_addr);
        chk("pwdata", pwdata, m_wdata);
        chk("pwrite", pwrite, m_write);
        chk("rdata", rdata, e_rdata);
    endtask

    // One clock: model advances at the edge, DUT compared at the falling edge.
    task automatic cycle();
        @(posedge pclk);
        if (!prst) model_edge();
        @(negedge pclk);
        compare_all();
        prdata = mem[paddr];
    endtask

    task automatic set_req(input int i, input bit r, input bit wr, input logic [7:0] a, input logic [7:0] d);
        req[i] = r; req_write[i] = wr; req_addr[8*i +: 8] = a; req_wdata[8*i +: 8] = d;
    endtask

    task automatic drive_rand(input int ready_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (e_gnt[i]) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
                else
                    req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 99) < 40) begin
                set_req(i, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
            end
        end
        pready = ($urandom_range(0, 99) < ready_pct);
    endtask

    int pcts [4] = '{100, 70, 30, 5};

    initial begin
        logic [NREQ-1:0] seq [4];
        int gi, n;

        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        prst = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; prdata = '0;
        model_reset();
        cycle();
        cycle();
        @(negedge pclk);
        prst = 1'b0;

        // Single write from requester 0
        set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        pready = 1'b1;
        cycle();
        chk("t1_gnt", gnt, 1);
        chk("t1_psel_alone", {psel, pen}, 2'b10);
        req[0] = 1'b0;
        cycle();
        chk("t1_pen", {psel, pen}, 2'b11);
        cycle();
        chk("t1_done", done, 1);
        cycle();

        // Read-back from requester 1
        set_req(1, 1'b1, 1'b0, 8'h10, 8'h00);
        cycle();
        req[1] = 1'b0;
        cycle();
        cycle();
        chk("t2_done", done, 2);
        chk("t2_rdata", rdata, 8'hA5);
        chk("t2_err", err, 0);
        cycle();

        // Contention: both held high, reading 0x10
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h10, 8'h00);
        gi = 0;
        for (int k = 0; k < 4; k++) seq[k] = '0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (gnt != 0 && gi < 4) begin seq[gi] = gnt; gi++; end
        end
        for (int k = 0; k < 4; k++) chk("rr_seq", seq[k], (k % 2 == 0) ? 1 : 2);
        req = '0;
        repeat (4) cycle();

        // Timeout: slave never ready
        set_req(0, 1'b1, 1'b0, 8'h03, 8'h00);
        pready = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (gnt != 0) req = '0;
            if (pen) n++;
            if (done != 0) break;
        end
        chk("to_access_cycles", n, TIMEOUT);
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_rdata", rdata, 8'hA5);
        pready = 1'b1;
        repeat (2) cycle();

        // Randomized traffic with varying slave wait behaviour
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 500; c++) begin
                drive_rand(pcts[b]);
                cycle();
            end
        end

        // Reset in the middle of ACCESS
        req = '0; pready = 1'b1;
        repeat (6) cycle();
        set_req(0, 1'b1, 1'b0, 8'h05, 8'h00);
        pready = 1'b0;
        for (int c = 0; c < 10 && !(m_busy && m_acc); c++) begin
            cycle();
            if (e_gnt != 0) req = '0;
        end
        chk("mr_in_access", pen, 1);
        #2;
        prst = 1'b1;
        model_reset();
        #1;
        chk("mr_psel", psel, 0);
        chk("mr_pen", pen, 0);
        chk("mr_gnt", gnt, 0);
        chk("mr_done", done, 0);
        cycle();
        prst = 1'b0;
        pready = 1'b1;
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_req(1, 1'b1, 1'b1, 8'h02, 8'h5A);
        cycle();
        chk("ptr_rst_gnt", gnt, 1);
        req[0] = 1'b0;
        for (int c = 0; c < 60; c++) begin
            drive_rand(80);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- APB master front end that shares one APB slave (8-bit address, 8-bit data, psel/pen/pready handshake) between NREQ local requesters.
- Arbitrates round-robin, sequences the IDLE->SETUP->ACCESS protocol, and returns read data plus a per-requester completion pulse.
- Sits between the requesting blocks and the APB slave memory; it is the only driver of the APB bus.

Parameters:
- NREQ, 2, number of requesters (2..8)
- TIMEOUT, 15, maximum ACCESS cycles waiting for pready before abort; 0 disables the timeout
- TO_W, 4, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT

Ports:
- pclk  in  1  clock, all logic on rising edge
- prst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester transfer request, level
- req_write  in  NREQ  per-requester direction, 1 = write
- req_addr  in  8*NREQ  per-requester address, requester i at bits [8i+7:8i]
- req_wdata  in  8*NREQ  per-requester write data, same packing
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted
- done  out  NREQ  one-hot, one-cycle pulse: transfer finished
- err  out  1  one-cycle pulse with done when the transfer timed out
- rdata  out  8  read data of the last completed read
- psel  out  1  APB select
- pen  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  8  APB address
- pwdata  out  8  APB write data
- pready  in  1  APB slave ready
- prdata  in  8  APB slave read data

Behaviour:
- All outputs registered. On prst (asynchronous, any state, including mid-transfer): state = IDLE; psel, pen, pwrite, paddr, pwdata, gnt, done, err, rdata = 0; round-robin pointer last = NREQ-1; timeout count = 0. No partial transfer is resumed after reset.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, req != 0 at edge:
  - Winner = first set bit scanning last+1, last+2, ... modulo NREQ.
  - Capture the winner's addr/wdata/write into paddr/pwdata/pwrite.
  - psel = 1, pen = 0, gnt[winner] = 1 for one cycle, last = winner, go to SETUP.
- IDLE, req == 0: outputs hold; paddr, pwdata and pwrite keep their last values.
- SETUP: unconditional; next edge sets pen = 1 and goes to ACCESS. The timeout counter clears.
- ACCESS, pready = 1 at edge:
  - psel = 0, pen = 0, done[winner] = 1 for one cycle.
  - If pwrite = 0, rdata = prdata sampled at this edge. Writes leave rdata unchanged.
  - Go to IDLE.
- ACCESS, pready = 0: hold psel, pen and address/data; counter increments.
  - When the counter reaches TIMEOUT (TIMEOUT != 0), complete exactly as on pready, except err = 1 and rdata is unchanged.
- Latency: req seen at edge E0 -> gnt and psel high after E0; pen high after E0+1; done after E0+2 for a zero-wait slave. Minimum 3 cycles per transfer; one idle cycle between transfers (base build).
- Requester rules:
  - Hold req, addr, wdata and write stable until gnt is seen.
  - req still high after done is a new request.
  - Requests arriving in SETUP/ACCESS wait; the arbiter samples req only in IDLE.
- Simultaneous requests: exactly one gnt bit ever set. Starvation-free: each requester waits at most NREQ-1 transfers.
- paddr, pwdata and pwrite never change while psel = 1.

Optional Feature:
- Macro: APB_ARB_BACK2BACK_EN.
- Defined: at ACCESS completion, if req (excluding the completing requester's same-cycle bit) is non-zero, arbitrate in the same edge and go directly to SETUP.
  - psel stays 1, pen drops to 0, new gnt pulses together with done.
  - Throughput is one transfer per 2 cycles with a zero-wait slave.
- Undefined: always return to IDLE as above.

Test Plan:
- Reset then single write: req=01, addr0=0x10, wdata0=0xA5, write0=1 -> gnt=01 next cycle; psel 1 cycle alone, then psel+pen; done=01 two cycles after gnt; paddr=0x10, pwdata=0xA5 throughout.
- Read-back: requester 1 reads 0x10 after the write above -> done=10, rdata=0xA5, err=0.
- Contention: req=11 held continuously, both requesters rearming after done -> gnt sequence 01,10,01,10; never two gnt bits set at once.
- Timeout: slave holds pready=0, TIMEOUT=15 -> exactly 15 ACCESS cycles, then done and err pulse together, psel=pen=0, rdata unchanged.
- Reset mid-ACCESS: assert prst between clock edges -> psel, pen, gnt and done drop to 0 immediately; after release, req=10 is granted first only if req0 is low, else req0 first (pointer reset).
- APB_ARB_BACK2BACK_EN defined, req=11: psel stays high across transfers; second gnt coincides with the first done; two transfers complete in 4 cycles after the first gnt.
